// File: rtl/dna_seq_pkg.sv
// dna_seq_pkg: shared state encoding and DNA field widths for the DNA read sequencer
package dna_seq_pkg;
  typedef enum logic [2:0] {IDLE, WAIT, LOAD, SHIFT, CMP, DONE} state_t;
  localparam int DNA_FACTORY_W = 57;
  localparam int DNA_FUSE_W = 7;
  localparam int DNA_W = 64;
endpackage

// File: rtl/dna_clk_gen.sv
// dna_clk_gen: free-running divided DNA_PORT clock with a one-cycle falling-edge strobe
// Ports: clk/rst system clock and async reset; dna_clk_o divided clock (0 in reset);
//        fall_tick_o high on the clk cycle whose edge drives dna_clk_o 1->0.
module dna_clk_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic dna_clk_o,
  output logic fall_tick_o
);
  logic [7:0] cnt_q, cnt_d;
  logic       tc;
  assign tc = cnt_q == 8'(DIV - 1);
  assign cnt_d = tc ? '0 : cnt_q + 8'd1;
  assign fall_tick_o = tc & dna_clk_o;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      dna_clk_o <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dna_clk_o <= tc ? ~dna_clk_o : dna_clk_o;
    end
  end
endmodule

// File: rtl/dna_read_sequencer.sv
// dna_read_sequencer: reads the 57 factory DNA bits, appends fuse bits and compares to an expected ID
// Ports: clk/rst system clock and async reset; start_i (re)read request when idle/done;
//        busy_o, valid_o, match_o, dna_value_o result interface;
//        dna_clk_o/dna_read_o/dna_shift_o/dna_din_o drive DNA_PORT, dna_dout_i is its DOUT.
module dna_read_sequencer
  import dna_seq_pkg::*;
#(
  parameter int unsigned       DIV          = 2,
  parameter int unsigned       STARTUP_CYC  = 8,
  parameter bit                AUTO_START   = 1'b1,
  parameter logic [DNA_FUSE_W-1:0] LOW_BITS = 7'h12,
  parameter logic [DNA_W-1:0]  EXPECTED_DNA = 64'h01A18E10_A0D80E12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic             match_o,
  output logic [DNA_W-1:0] dna_value_o,
  output logic             dna_clk_o,
  output logic             dna_read_o,
  output logic             dna_shift_o,
  output logic             dna_din_o,
  input  logic             dna_dout_i
);
  state_t                   state_q, state_d;
  logic [15:0]              dly_q, dly_d;
  logic [5:0]               bit_cnt_q, bit_cnt_d;
  logic [DNA_FACTORY_W-1:0] sr_q, sr_d;
  logic                     read_q, read_d, shift_q, shift_d;
  logic                     valid_q, valid_d, match_q, match_d;
  logic [DNA_W-1:0]         value_q, value_d, full;
  logic                     auto_q, fall_tick, go;
  dna_clk_gen #(.DIV(DIV)) u_clk (
    .clk        (clk),
    .rst        (rst),
    .dna_clk_o  (dna_clk_o),
    .fall_tick_o(fall_tick)
  );
  assign full = {sr_q, LOW_BITS};
  assign go = start_i | (auto_q & (state_q == IDLE));
  assign busy_o = (state_q != IDLE) && (state_q != DONE);
  assign valid_o = valid_q;
  assign match_o = match_q;
  assign dna_value_o = value_q;
  assign dna_read_o = read_q;
  assign dna_shift_o = shift_q;
  assign dna_din_o = 1'b0;
  always_comb begin
    state_d = state_q;
    dly_d = dly_q;
    bit_cnt_d = bit_cnt_q;
    sr_d = sr_q;
    read_d = read_q;
    shift_d = shift_q;
    valid_d = valid_q;
    match_d = match_q;
    value_d = value_q;
    case (state_q)
      IDLE, DONE: if (go) begin
        state_d = WAIT;
        valid_d = 1'b0;
        match_d = 1'b0;
        dly_d = 16'(STARTUP_CYC);
      end
      WAIT: begin
        state_d = dly_q == '0 ? LOAD : WAIT;
        dly_d = dly_q == '0 ? dly_q : dly_q - 16'd1;
      end
      // DOUT already presents the MSB after the READ edge, so it is sampled as the
      // shift phase begins; the 57th shift edge only pushes DIN into the port.
      LOAD: if (fall_tick) begin
        if (!read_q) read_d = 1'b1;
        else begin
          read_d = 1'b0;
          shift_d = 1'b1;
          sr_d = {sr_q[DNA_FACTORY_W-2:0], dna_dout_i};
          bit_cnt_d = 6'd1;
          state_d = SHIFT;
        end
      end
      SHIFT: if (fall_tick) begin
        if (bit_cnt_q == 6'd57) begin
          shift_d = 1'b0;
          state_d = CMP;
        end else begin
          sr_d = {sr_q[DNA_FACTORY_W-2:0], dna_dout_i};
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
      CMP: begin
        value_d = full;
        match_d = full == EXPECTED_DNA;
        valid_d = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dly_q <= '0;
      bit_cnt_q <= '0;
      sr_q <= '0;
      read_q <= 1'b0;
      shift_q <= 1'b0;
      valid_q <= 1'b0;
      match_q <= 1'b0;
      value_q <= '0;
      auto_q <= AUTO_START;
    end else begin
      state_q <= state_d;
      dly_q <= dly_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q <= sr_d;
      read_q <= read_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      match_q <= match_d;
      value_q <= value_d;
      auto_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dna_read_sequencer.sv
// tb_dna_read_sequencer: directed checks of three sequencer instances against a DNA_PORT model
module tb_dna_read_sequencer;
  localparam logic [63:0] EXP = 64'h01A18E10_A0D80E12;
  localparam logic [56:0] GOOD = 57'h03431C2141B01C;
  logic clk = 1'b0;
  logic [2:0] rst, start;
  wire [2:0] busy, valid, match, dclk, rd, sh, din, dout;
  wire [63:0] val [3];
  logic [56:0] factory;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    logic [56:0] m_q;
    int n_rd = 0, n_sh = 0, n_bad = 0, n_done = 0;
    logic pr = 1'b0, ps = 1'b0, pc = 1'b0;
    always @(posedge dclk[g]) begin
      if (rd[g]) begin m_q <= factory; n_rd++; end
      else if (sh[g]) begin m_q <= {m_q[55:0], din[g]}; n_sh++; end
    end
    assign dout[g] = m_q[56];
    always @(posedge valid[g]) n_done++;
    always @(negedge clk) begin
      if ((rd[g] !== pr || sh[g] !== ps) && !(pc === 1'b1 && dclk[g] === 1'b0)) n_bad++;
      pr = rd[g];
      ps = sh[g];
      pc = dclk[g];
    end
    dna_read_sequencer #(
      .DIV(g == 0 ? 2 : g == 1 ? 1 : 5),
      .AUTO_START(g == 0 ? 1'b1 : 1'b0)
    ) dut (
      .clk(clk), .rst(rst[g]), .start_i(start[g]), .busy_o(busy[g]), .valid_o(valid[g]),
      .match_o(match[g]), .dna_value_o(val[g]), .dna_clk_o(dclk[g]), .dna_read_o(rd[g]),
      .dna_shift_o(sh[g]), .dna_din_o(din[g]), .dna_dout_i(dout[g])
    );
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask
  task automatic wait_valid(input int g, output int c);
    c = 0;
    while (valid[g] !== 1'b1 && c < 3000) begin
      @(negedge clk);
      c++;
    end
  endtask
  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask
  initial begin
    int c, lat, b_rd, b_sh, b_done;
    logic [63:0] first;
    factory = GOOD;
    rst = 3'b111;
    start = 3'b000;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {busy[0], valid[0], match[0], dclk[0], rd[0], sh[0]}, 64'd0);
    chk("reset_value", val[0], 64'd0);
    rst = 3'b000;
    // 1: automatic run after reset with the matching die
    wait_valid(0, c);
    chk("t1_done", 64'(c < 3000), 64'd1);
    chk("t1_value", val[0], EXP);
    chk("t1_match", match[0], 1);
    chk("t1_read_edges", u[0].n_rd, 1);
    chk("t1_shift_edges", u[0].n_sh, 57);
    chk("t1_din", din[0], 0);
    // 2: factory bit 0 flipped, rerun by reset
    factory = GOOD ^ 57'd1;
    b_rd = u[0].n_rd;
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    wait_valid(0, c);
    chk("t2_value", val[0], EXP ^ 64'h80);
    chk("t2_match", match[0], 0);
    repeat (400) @(negedge clk);
    chk("t2_no_rerun", u[0].n_rd - b_rd, 1);
    chk("t2_idle", {busy[0], valid[0]}, 64'b01);
    // 4: start pulses during SHIFT are ignored
    factory = GOOD;
    b_rd = u[0].n_rd;
    b_sh = u[0].n_sh;
    b_done = u[0].n_done;
    pulse_start(0);
    c = 0;
    while (sh[0] !== 1'b1 && c < 3000) begin @(negedge clk); c++; end
    while (sh[0] === 1'b1 && c < 3000) begin
      repeat (10) @(negedge clk);
      c += 10;
      if (sh[0] === 1'b1) pulse_start(0);
    end
    wait_valid(0, c);
    repeat (300) @(negedge clk);
    chk("t4_shift_edges", u[0].n_sh - b_sh, 57);
    chk("t4_read_edges", u[0].n_rd - b_rd, 1);
    chk("t4_completions", u[0].n_done - b_done, 1);
    chk("t4_value", val[0], EXP);
    chk("t4_idle", {busy[0], valid[0], match[0]}, 64'b011);
    // 5: reset in the middle of the shift phase
    b_sh = u[0].n_sh;
    pulse_start(0);
    c = 0;
    while (u[0].n_sh - b_sh < 30 && c < 3000) begin @(negedge clk); c++; end
    rst[0] = 1'b1;
    #1;
    chk("t5_async_ctl", {busy[0], valid[0], match[0], dclk[0], rd[0], sh[0]}, 64'd0);
    chk("t5_async_value", val[0], 64'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    b_sh = u[0].n_sh;
    wait_valid(0, c);
    chk("t5_rerun_shift_edges", u[0].n_sh - b_sh, 57);
    chk("t5_rerun_value", val[0], EXP);
    chk("t5_rerun_match", match[0], 1);
    // 3 and 6: manual start, DIV=1
    chk("t3_no_auto", {busy[1], valid[1]}, 64'd0);
    pulse_start(1);
    wait_valid(1, c);
    lat = c + 1;
    chk("t6_div1_lat_lo", 64'(lat >= 8 + 2 * 1 * 58), 1);
    chk("t6_div1_lat_hi", 64'(lat <= 8 + 2 * 1 * 60 + 4), 1);
    chk("t3_value", val[1], EXP);
    chk("t3_match", match[1], 1);
    first = val[1];
    pulse_start(1);
    chk("t3_restart_ctl", {busy[1], valid[1], match[1]}, 64'b100);
    wait_valid(1, c);
    chk("t3_same_value", val[1], first);
    chk("t6_div1_strobe_timing", u[1].n_bad, 0);
    // 6: DIV=5
    pulse_start(2);
    wait_valid(2, c);
    lat = c + 1;
    chk("t6_div5_lat_lo", 64'(lat >= 8 + 2 * 5 * 58), 1);
    chk("t6_div5_lat_hi", 64'(lat <= 8 + 2 * 5 * 60 + 4), 1);
    chk("t6_div5_value", val[2], EXP);
    chk("t6_div5_strobe_timing", u[2].n_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
